// File: rtl/uart_baud_gen_if.sv
// Configuration, start-request and strobe signals between the UART engines
// and the baud generator.
interface uart_baud_gen_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              cfg_load;
    logic              cfg_pend;
    logic              rx_start;
    logic              tx_start;
    logic              ovs_tick;
    logic              rx_mid;
    logic              tx_bit;

    modport master (
        output div_int, div_frac, cfg_load, rx_start, tx_start,
        input  cfg_pend, ovs_tick, rx_mid, tx_bit
    );

    modport slave (
        input  div_int, div_frac, cfg_load, rx_start, tx_start,
        output cfg_pend, ovs_tick, rx_mid, tx_bit
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional-N UART baud generator: oversample tick, RX mid-bit strobe and
// TX bit-boundary strobe, with a shadowed divisor applied on period boundaries.
module uart_baud_gen #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OVS      = 16,
    parameter int unsigned DEF_INT  = 13,
    parameter int unsigned DEF_FRAC = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_baud_gen_if.slave bus
);
    localparam int unsigned PH_W      = $clog2(OVS);
    localparam int unsigned RST_INT_U = (DEF_INT < 2) ? 2 : DEF_INT;

    localparam logic [DIV_W-1:0]  RST_INT   = DIV_W'(RST_INT_U);
    localparam logic [DIV_W-1:0]  RST_LAST  = DIV_W'(RST_INT_U - 1);
    localparam logic [FRAC_W-1:0] RST_FRAC  = FRAC_W'(DEF_FRAC);
    localparam logic [PH_W-1:0]   RX_MID_PH = PH_W'(OVS / 2 - 1);
    localparam logic [PH_W-1:0]   TX_BIT_PH = PH_W'(OVS - 1);

    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  shd_int;
    logic [FRAC_W-1:0] shd_frac;
    logic              pend;

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  last;
    logic [FRAC_W-1:0] acc;

    logic [PH_W-1:0]   rx_ph;
    logic [PH_W-1:0]   tx_ph;

    logic              ovs_q;
    logic              rx_mid_q;
    logic              tx_bit_q;

    logic              tc;
    logic              apply;
    logic [DIV_W-1:0]  nxt_int;
    logic [FRAC_W-1:0] nxt_frac;
    logic [FRAC_W-1:0] acc_base;
    logic [FRAC_W:0]   sum;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    // The length of the next period (last = L-1) is resolved at tc, so the
    // terminal compare is a plain equality against a register.
    always_comb begin
        tc       = (cnt == last);
        apply    = tc && pend && !bus.cfg_load;
        nxt_int  = apply ? clamp_div(shd_int) : act_int;
        nxt_frac = apply ? shd_frac : act_frac;
        acc_base = apply ? '0 : acc;
        sum      = {1'b0, acc_base} + {1'b0, nxt_frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            acc  <= '0;
            last <= RST_LAST;
        end else if (tc) begin
            cnt  <= '0;
            acc  <= sum[FRAC_W-1:0];
            last <= nxt_int - 1'b1 + {{(DIV_W-1){1'b0}}, sum[FRAC_W]};
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

    // A load in the same cycle as tc wins over clearing pend, deferring the
    // apply to the following tc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_int  <= RST_INT;
            act_frac <= RST_FRAC;
            shd_int  <= RST_INT;
            shd_frac <= RST_FRAC;
            pend     <= 1'b0;
        end else begin
            if (apply) begin
                act_int  <= nxt_int;
                act_frac <= nxt_frac;
            end
            if (bus.cfg_load) begin
                shd_int  <= bus.div_int;
                shd_frac <= bus.div_frac;
                pend     <= 1'b1;
            end else if (apply) begin
                pend     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ph <= '0;
            tx_ph <= '0;
        end else begin
            if (!bus.rx_start)
                rx_ph <= '0;
            else if (tc)
                rx_ph <= rx_ph + 1'b1;
            if (!bus.tx_start)
                tx_ph <= '0;
            else if (tc)
                tx_ph <= tx_ph + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovs_q    <= 1'b0;
            rx_mid_q <= 1'b0;
            tx_bit_q <= 1'b0;
        end else begin
            ovs_q    <= tc;
            rx_mid_q <= tc && bus.rx_start && (rx_ph == RX_MID_PH);
            tx_bit_q <= tc && bus.tx_start && (tx_ph == TX_BIT_PH);
        end
    end

    assign bus.ovs_tick = ovs_q;
    assign bus.rx_mid   = rx_mid_q;
    assign bus.tx_bit   = tx_bit_q;
    assign bus.cfg_pend = pend;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: stimulus queues expected strobe
// intervals, a negedge monitor pops and checks them as strobes appear.
module tb_uart_baud_gen;
    typedef struct {
        int ref_cyc;   // -1: measured from the previous strobe of the same kind
        int lo;
        int hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   last_tick = 0;
    int   last_rx = 0;
    int   last_tx = 0;

    exp_t tick_q[$];
    exp_t rx_q[$];
    exp_t tx_q[$];

    // Default cadence for I=13, F=9 starting from acc=0 after reset.
    int   def_gaps[16] = '{13, 14, 13, 14, 13, 14, 13, 14,
                           14, 13, 14, 13, 14, 13, 14, 14};

    uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) bus ();

    uart_baud_gen #(
        .DIV_W   (16),
        .FRAC_W  (4),
        .OVS     (16),
        .DEF_INT (13),
        .DEF_FRAC(9)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_win(input string name, input exp_t e, input int now, input int prev);
        int d;
        d = (e.ref_cyc < 0) ? now - prev : now - e.ref_cyc;
        n_chk++;
        if (d < e.lo || d > e.hi) begin
            n_err++;
            $display("FAIL %s: interval %0d cycles, required %0d..%0d", name, d, e.lo, e.hi);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ovs_tick) begin
                if (tick_q.size() > 0) check_win("ovs_gap", tick_q.pop_front(), cyc, last_tick);
                last_tick = cyc;
            end
            if (bus.rx_mid) begin
                if (rx_q.size() > 0) check_win("rx_mid_time", rx_q.pop_front(), cyc, last_rx);
                else chk_eq("rx_mid_unexpected", 1, 0);
                last_rx = cyc;
            end
            if (bus.tx_bit) begin
                if (tx_q.size() > 0) check_win("tx_bit_time", tx_q.pop_front(), cyc, last_tx);
                else chk_eq("tx_bit_unexpected", 1, 0);
                last_tx = cyc;
            end
        end
    end

    task automatic push(input int kind, input int ref_cyc, input int lo, input int hi);
        exp_t e;
        e.ref_cyc = ref_cyc;
        e.lo = lo;
        e.hi = hi;
        if (kind == 0) tick_q.push_back(e);
        else if (kind == 1) rx_q.push_back(e);
        else tx_q.push_back(e);
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ovs_tick && n < 200);
        #1;
        if (!bus.ovs_tick) chk_eq(name, 0, 1);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((tick_q.size() + rx_q.size() + tx_q.size()) != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk_eq(name, tick_q.size() + rx_q.size() + tx_q.size(), 0);
        tick_q.delete();
        rx_q.delete();
        tx_q.delete();
    endtask

    task automatic load(input int i, input int f);
        bus.div_int  = 16'(i);
        bus.div_frac = 4'(f);
        bus.cfg_load = 1'b1;
        @(negedge clk);
        #1;
        bus.cfg_load = 1'b0;
    endtask

    task automatic default_cadence(input string name);
        int t0;
        wait_tick({name, "_first_tick"});
        foreach (def_gaps[k]) push(0, -1, def_gaps[k], def_gaps[k]);
        t0 = cyc;
        repeat (16) wait_tick({name, "_tick"});
        chk_eq({name, "_span16"}, cyc - t0, 217);
        drain({name, "_drain"}, 20);
    endtask

    initial begin
        bus.div_int  = '0;
        bus.div_frac = '0;
        bus.cfg_load = 1'b0;
        bus.rx_start = 1'b0;
        bus.tx_start = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk_eq("rst_ovs_tick", int'(bus.ovs_tick), 0);
        chk_eq("rst_rx_mid", int'(bus.rx_mid), 0);
        chk_eq("rst_tx_bit", int'(bus.tx_bit), 0);
        chk_eq("rst_cfg_pend", int'(bus.cfg_pend), 0);
        rst_n = 1'b1;
        default_cadence("def");

        // Integer divisor 10, TX cadence.
        wait_tick("tx_sync");
        load(10, 0);
        chk_eq("tx_pend_set", int'(bus.cfg_pend), 1);
        wait_tick("tx_apply");
        chk_eq("tx_pend_clr", int'(bus.cfg_pend), 0);
        repeat (3) push(0, -1, 10, 10);
        bus.tx_start = 1'b1;
        push(2, cyc, 150, 161);
        push(2, -1, 160, 160);
        push(2, -1, 160, 160);
        drain("tx_drain", 600);
        bus.tx_start = 1'b0;

        // RX mid-bit, drop mid-bit, then restart alongside TX.
        bus.rx_start = 1'b1;
        push(1, cyc, 70, 81);
        push(1, -1, 160, 160);
        drain("rx_drain", 400);
        repeat (40) @(negedge clk);
        #1;
        bus.rx_start = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        bus.rx_start = 1'b1;
        bus.tx_start = 1'b1;
        push(1, cyc, 70, 81);
        push(2, cyc, 150, 161);
        drain("rxtx_drain", 250);
        bus.rx_start = 1'b0;
        bus.tx_start = 1'b0;

        // Load landing on the tc cycle is deferred by one period.
        wait_tick("coin_sync");
        repeat (9) @(negedge clk);
        #1;
        bus.div_int  = 16'd20;
        bus.div_frac = 4'd0;
        bus.cfg_load = 1'b1;
        @(negedge clk);
        #1;
        bus.cfg_load = 1'b0;
        chk_eq("coin_on_tick", int'(bus.ovs_tick), 1);
        chk_eq("coin_pend_set", int'(bus.cfg_pend), 1);
        push(0, -1, 10, 10);
        push(0, -1, 20, 20);
        push(0, -1, 20, 20);
        wait_tick("coin_apply");
        chk_eq("coin_pend_clr", int'(bus.cfg_pend), 0);
        drain("coin_drain", 100);

        // Back-to-back loads of 0 then 1; clamped to 2.
        wait_tick("clamp_sync");
        bus.div_int  = 16'd0;
        bus.div_frac = 4'd0;
        bus.cfg_load = 1'b1;
        @(negedge clk);
        #1;
        bus.div_int  = 16'd1;
        @(negedge clk);
        #1;
        bus.cfg_load = 1'b0;
        chk_eq("clamp_pend_set", int'(bus.cfg_pend), 1);
        push(0, -1, 20, 20);
        repeat (8) push(0, -1, 2, 2);
        drain("clamp_drain", 100);
        chk_eq("clamp_pend_clr", int'(bus.cfg_pend), 0);

        // Reset mid-character with a load pending.
        wait_tick("rst_sync");
        load(10, 0);
        wait_tick("rst_apply10");
        bus.rx_start = 1'b1;
        bus.tx_start = 1'b1;
        repeat (4) wait_tick("rst_run");
        load(30, 0);
        chk_eq("rst_pend_before", int'(bus.cfg_pend), 1);
        rst_n = 1'b0;
        #1;
        chk_eq("arst_ovs_tick", int'(bus.ovs_tick), 0);
        chk_eq("arst_rx_mid", int'(bus.rx_mid), 0);
        chk_eq("arst_tx_bit", int'(bus.tx_bit), 0);
        chk_eq("arst_cfg_pend", int'(bus.cfg_pend), 0);
        bus.rx_start = 1'b0;
        bus.tx_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        default_cadence("post_rst");
        chk_eq("post_rst_pend", int'(bus.cfg_pend), 0);

        repeat (50) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Runtime-programmable UART baud generator with a fractional divider and 16x-style oversampling. It produces a free-running oversample strobe, a receive mid-bit strobe phase-aligned to the receiver's start request, and a transmit bit-boundary strobe. The divisor can be reloaded glitch-free while traffic runs. It sits between the system clock domain and the UART RX/TX shift engines, and replaces the fixed-rate single-channel divider.

## Interface
- `DIV_W`, 16, width of integer divisor
- `FRAC_W`, 4, width of fractional divisor (units of 1/2^FRAC_W clock)
- `OVS`, 16, oversample ticks per bit; power of two, ≥4
- `DEF_INT`, 13, integer divisor after reset (25 MHz, 115200 baud, OVS=16)
- `DEF_FRAC`, 9, fractional divisor after reset
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `div_int`  in  DIV_W  new integer divisor, sampled on `cfg_load`
- `div_frac`  in  FRAC_W  new fractional divisor, sampled on `cfg_load`
- `cfg_load`  in  1  one-cycle request to latch `div_int`/`div_frac` into the shadow registers
- `cfg_pend`  out  1  shadow divisor latched but not yet applied
- `rx_start`  in  1  level; high while the receiver is framing a character
- `tx_start`  in  1  level; high while the transmitter is sending a character
- `ovs_tick`  out  1  one-cycle oversample strobe
- `rx_mid`  out  1  one-cycle strobe at the middle of each received bit
- `tx_bit`  out  1  one-cycle strobe at each transmit bit boundary

## Operation
- **Active divisor (I, F).** Reset loads I = DEF_INT and F = DEF_FRAC. Any I < 2 is clamped to 2 when applied.
- **Fractional generator.**
  - Period counter `cnt` (DIV_W bits) and accumulator `acc` (FRAC_W bits) run continuously from reset.
  - Period length is L = I + c, where c is the carry of `acc` + F computed at the start of the period. The sum is written back to `acc` mod 2^FRAC_W.
  - The terminal condition tc is true when `cnt` == L−1. On tc, `cnt` returns to 0.
  - The average period is I + F/2^FRAC_W clocks.
- **Shadow load.**
  - `cfg_load` captures `div_int`/`div_frac` into the shadow registers and sets `cfg_pend`.
  - A repeated `cfg_load` while `cfg_pend` is set overwrites the shadow values.
  - On the first tc strictly after the capture cycle: shadow → active, `acc` cleared to 0, `cfg_pend` cleared. The next period uses the new values.
  - If `cfg_load` and tc occur in the same cycle, the values are captured and applied at the following tc.
- **RX channel.**
  - `rx_ph` (log2 OVS bits) is held at 0 while `rx_start` is low.
  - On each tc with `rx_start` high, `rx_ph` increments mod OVS.
  - `rx_mid` fires on the tc where `rx_ph` == OVS/2−1.
- **TX channel.**
  - `tx_ph` is held at 0 while `tx_start` is low.
  - On each tc with `tx_start` high, `tx_ph` increments mod OVS.
  - `tx_bit` fires on the tc where `tx_ph` == OVS−1.
- **Channel independence.** RX and TX share the tick but are otherwise independent; both may be active together.
- **Dropping a start request.** A start input going low mid-bit clears that channel's phase on the next clock. No further strobes are issued for that channel until it restarts.

## Timing
- **Output registers.** All outputs are registered. `ovs_tick`, `rx_mid` and `tx_bit` are high in the cycle after tc, all aligned to each other.
- **Reset values.** All outputs reset to 0. `cnt`, `acc`, `rx_ph` and `tx_ph` reset to 0.
- **Strobe width.** Each strobe is exactly one cycle. The spacing between `ovs_tick` pulses is I or I+1 cycles, never less than 2.
- **First `rx_mid` latency.** Measured from the first cycle `rx_start` is sampled high: between (OVS/2−1)·L and (OVS/2)·L + 1 cycles. This gives a phase uncertainty of one oversample period.
- **First `tx_bit` latency.** Between (OVS−1)·L and OVS·L + 1 cycles. After that, exactly OVS periods apart.
- **Start sampling.** A start input sampled high in the same cycle as tc counts that tc.
- **`cfg_pend` timing.**
  - Goes high the cycle after `cfg_load`.
  - Goes low the cycle after the applying tc.
- **Reset mid-operation.** Everything returns to the defaults asynchronously. Any pending load is discarded.

## Test plan
- **Reset defaults.** Release reset, hold `rx_start`/`tx_start` low → `ovs_tick` gaps alternate 13/14 cycles; exactly 217 cycles over 16 ticks; `rx_mid`=`tx_bit`=0.
- **Integer divisor, TX spacing.** `cfg_load` with I=10, F=0, then raise `tx_start` → `cfg_pend` clears after the next tick; `tx_bit` repeats every 160 cycles; first `tx_bit` within 150–161 cycles of the rise.
- **RX mid-bit alignment.** I=10, F=0; raise `rx_start` → first `rx_mid` within 70–81 cycles, then every 160 cycles. Drop `rx_start` mid-bit → no `rx_mid`; on re-raise the latency restarts.
- **Load coincident with tc.** Assert `cfg_load` (I=20) in the tc cycle → old period length retained for one more period; new 20-cycle periods start after the following tick.
- **Clamp and back-to-back load.** `cfg_load` I=0, then I=1 on the next cycle before tc → applied I=2; `ovs_tick` every 2 cycles; no zero-gap strobes.
- **Asynchronous reset mid-run.** Assert `rst_n` low mid-character with `cfg_pend`=1 → all outputs 0 immediately; after release, the default 13/14 cadence resumes and the pending load is lost.
